// File: rtl/pd_pwr_pkg.sv
// Shared types and default parameters for the power-domain responder.
// Consumed by pd_pwr_responder, pd_switch_sequencer and pd_pwr_responder_if.
package pd_pwr_pkg;

  localparam int SEGS_DEF      = 4;
  localparam int STAGE_DLY_DEF = 2;
  localparam int IDLE_HOLD_DEF = 3;
  localparam int CNT_W_DEF     = 4;

  typedef enum logic [2:0] {
    PD_OFF      = 3'd0,
    PD_RAMP     = 3'd1,
    PD_ON       = 3'd2,
    PD_DRAIN    = 3'd3,
    PD_QUIESCED = 3'd4
  } pd_resp_state_t;

  // Rail is up and the controller may rely on it in these states.
  function automatic logic pd_powered(input pd_resp_state_t s);
    return (s == PD_ON) || (s == PD_DRAIN) || (s == PD_QUIESCED);
  endfunction

endpackage

// File: rtl/pd_pwr_responder_if.sv
// Controller/domain handshake bundle for one switchable power domain.
// master = controller/domain side driving requests, slave = the responder.
interface pd_pwr_responder_if
  import pd_pwr_pkg::*;
#(
  parameter int SEGS = SEGS_DEF
);
  logic            i_pwr_on_req;
  logic            o_pwr_on_ack;
  logic            i_hw_sleep_req;
  logic            o_hw_sleep_ack;
  logic            i_ret;
  logic            o_save_pulse;
  logic            o_restore_pulse;
  logic            i_txn_issue;
  logic            i_txn_done;
  logic            i_busy;
  logic            i_pwr_good;
  logic [SEGS-1:0] o_sw_en;
  logic            o_txn_block;
  logic            o_err;

  modport master (
    output i_pwr_on_req, i_hw_sleep_req, i_ret, i_txn_issue, i_txn_done,
           i_busy, i_pwr_good,
    input  o_pwr_on_ack, o_hw_sleep_ack, o_save_pulse, o_restore_pulse,
           o_sw_en, o_txn_block, o_err
  );

  modport slave (
    input  i_pwr_on_req, i_hw_sleep_req, i_ret, i_txn_issue, i_txn_done,
           i_busy, i_pwr_good,
    output o_pwr_on_ack, o_hw_sleep_ack, o_save_pulse, o_restore_pulse,
           o_sw_en, o_txn_block, o_err
  );
endinterface

// File: rtl/pd_switch_sequencer.sv
// Staged power-switch enable ramp: segment 0 on start, one more segment every
// STAGE_DLY cycles; all_on is registered one cycle after the last segment.
module pd_switch_sequencer
  import pd_pwr_pkg::*;
#(
  parameter int SEGS      = SEGS_DEF,
  parameter int STAGE_DLY = STAGE_DLY_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            clear,
  output logic            all_on,
  output logic [SEGS-1:0] sw_en
);
  localparam int TW = (STAGE_DLY > 1) ? $clog2(STAGE_DLY) : 1;

  logic [SEGS-1:0] sw_en_q, sw_en_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            all_on_q, all_on_d;

  always_comb begin
    sw_en_d  = sw_en_q;
    tmr_d    = tmr_q;
    all_on_d = &sw_en_q;
    if (clear) begin
      sw_en_d  = '0;
      tmr_d    = '0;
      all_on_d = 1'b0;
    end else if (start) begin
      sw_en_d  = SEGS'(1);
      tmr_d    = '0;
      all_on_d = 1'b0;
    end else if (sw_en_q[0] && !(&sw_en_q)) begin
      if (tmr_q == TW'(STAGE_DLY - 1)) begin
        sw_en_d = (sw_en_q << 1) | SEGS'(1);
        tmr_d   = '0;
      end else begin
        tmr_d = tmr_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_en_q  <= '0;
      tmr_q    <= '0;
      all_on_q <= 1'b0;
    end else begin
      sw_en_q  <= sw_en_d;
      tmr_q    <= tmr_d;
      all_on_q <= all_on_d;
    end
  end

  assign sw_en  = sw_en_q;
  assign all_on = all_on_q;

endmodule

// File: rtl/pd_pwr_responder.sv
// Domain-side power/sleep handshake responder with transaction drain tracking.
// Optional feature macro PD_RESP_RET_EN enables retention save/restore pulses.
module pd_pwr_responder
  import pd_pwr_pkg::*;
#(
  parameter int SEGS      = SEGS_DEF,
  parameter int STAGE_DLY = STAGE_DLY_DEF,
  parameter int IDLE_HOLD = IDLE_HOLD_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic              i_aon_clk,
  input  logic              i_soc_pwr_on_rst,
  pd_pwr_responder_if.slave bus
);
  localparam int QW = $clog2(IDLE_HOLD + 1);

  pd_resp_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [QW-1:0]    quiet_q, quiet_d;
  logic             err_q, err_d;

  logic            seq_start, seq_clear, seq_all_on;
  logic [SEGS-1:0] seq_sw_en;
  logic            blocked, issue_ok, cnt_full;

  assign blocked  = (state_q != PD_ON);
  assign issue_ok = bus.i_txn_issue && !blocked;
  assign cnt_full = &cnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      PD_OFF:      if (bus.i_pwr_on_req) state_d = PD_RAMP;
      PD_RAMP:     if (!bus.i_pwr_on_req) state_d = PD_OFF;
                   else if (seq_all_on && bus.i_pwr_good) state_d = PD_ON;
      PD_ON:       if (!bus.i_pwr_on_req) state_d = PD_OFF;
                   else if (bus.i_hw_sleep_req) state_d = PD_DRAIN;
      PD_DRAIN:    if (!bus.i_pwr_on_req) state_d = PD_OFF;
                   else if (!bus.i_hw_sleep_req) state_d = PD_ON;
                   else if (quiet_q >= QW'(IDLE_HOLD)) state_d = PD_QUIESCED;
      PD_QUIESCED: if (!bus.i_pwr_on_req) state_d = PD_OFF;
                   else if (!bus.i_hw_sleep_req) state_d = PD_ON;
      default:     state_d = PD_OFF;
    endcase
  end

  // Power removed before the sleep handshake completed is a protocol error.
  always_comb begin
    err_d = err_q;
    if (!bus.i_pwr_on_req && (state_q == PD_ON || state_q == PD_DRAIN)) err_d = 1'b1;
    if (bus.i_txn_issue && blocked) err_d = 1'b1;
    if (issue_ok && !bus.i_txn_done && cnt_full) err_d = 1'b1;
    if (bus.i_txn_done && !issue_ok && (cnt_q == '0)) err_d = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (issue_ok && !bus.i_txn_done) begin
      if (!cnt_full) cnt_d = cnt_q + CNT_W'(1);
    end else if (bus.i_txn_done && !issue_ok) begin
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    end
    if (state_d == PD_OFF && state_q != PD_OFF) cnt_d = '0;
  end

  always_comb begin
    quiet_d = '0;
    if (state_q == PD_DRAIN && cnt_q == '0 && !bus.i_busy)
      quiet_d = (quiet_q >= QW'(IDLE_HOLD)) ? quiet_q : quiet_q + QW'(1);
  end

  always_ff @(posedge i_aon_clk) begin
    if (i_soc_pwr_on_rst) begin
      state_q <= PD_OFF;
      cnt_q   <= '0;
      quiet_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quiet_q <= quiet_d;
      err_q   <= err_d;
    end
  end

  assign seq_clear = (state_d == PD_OFF);
  assign seq_start = (state_q == PD_OFF) && (state_d == PD_RAMP);

  pd_switch_sequencer #(
    .SEGS      (SEGS),
    .STAGE_DLY (STAGE_DLY)
  ) u_seq (
    .clk    (i_aon_clk),
    .rst    (i_soc_pwr_on_rst),
    .start  (seq_start),
    .clear  (seq_clear),
    .all_on (seq_all_on),
    .sw_en  (seq_sw_en)
  );

`ifdef PD_RESP_RET_EN
  logic ret_q, ret_d, save_q, save_d, restore_q, restore_d;

  always_comb begin
    ret_d     = bus.i_ret;
    save_d    = bus.i_ret && !ret_q;
    restore_d = !bus.i_ret && ret_q;
  end

  always_ff @(posedge i_aon_clk) begin
    if (i_soc_pwr_on_rst) begin
      ret_q     <= 1'b0;
      save_q    <= 1'b0;
      restore_q <= 1'b0;
    end else begin
      ret_q     <= ret_d;
      save_q    <= save_d;
      restore_q <= restore_d;
    end
  end

  assign bus.o_save_pulse    = save_q;
  assign bus.o_restore_pulse = restore_q;
`else
  assign bus.o_save_pulse    = 1'b0;
  assign bus.o_restore_pulse = 1'b0;
`endif

  assign bus.o_sw_en        = seq_sw_en;
  assign bus.o_pwr_on_ack   = pd_powered(state_q);
  assign bus.o_hw_sleep_ack = (state_q == PD_QUIESCED);
  assign bus.o_txn_block    = blocked;
  assign bus.o_err          = err_q;

endmodule

// File: tb/tb_pd_pwr_responder.sv
// Self-checking bench: directed handshake scenarios plus randomized controller
// traffic, compared every cycle against a behavioural model of the domain.
module tb_pd_pwr_responder;
  localparam int SEGS      = 4;
  localparam int STAGE_DLY = 2;
  localparam int IDLE_HOLD = 3;
  localparam int CNT_W     = 4;
  localparam int MAXC      = (1 << CNT_W) - 1;
  localparam int RAMP_MIN  = (SEGS - 1) * STAGE_DLY + 1;

  localparam int M_OFF = 0, M_RAMP = 1, M_ON = 2, M_DRAIN = 3, M_QUI = 4;

`ifdef PD_RESP_RET_EN
  localparam bit RET_EN = 1'b1;
`else
  localparam bit RET_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   chk_en = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  pd_pwr_responder_if #(.SEGS(SEGS)) bus ();

  pd_pwr_responder #(
    .SEGS(SEGS), .STAGE_DLY(STAGE_DLY), .IDLE_HOLD(IDLE_HOLD), .CNT_W(CNT_W)
  ) dut (
    .i_aon_clk        (clk),
    .i_soc_pwr_on_rst (rst),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Behavioural model: domain phase, ramp age, quiet run, outstanding count.
  int m_st = M_OFF, pre_st, m_age = 0, m_qrun = 0, m_out = 0, pre_out;
  bit m_err = 0, m_prev_ret = 0, m_save = 0, m_rest = 0;
  bit quiet_now, blk, iss;

  always @(posedge clk) begin
    if (rst) begin
      m_st = M_OFF; m_age = 0; m_qrun = 0; m_out = 0; m_err = 0;
      m_prev_ret = 0; m_save = 0; m_rest = 0;
    end else begin
      pre_st    = m_st;
      pre_out   = m_out;
      quiet_now = (pre_out == 0) && !bus.i_busy;
      blk       = (pre_st != M_ON);
      iss       = bus.i_txn_issue && !blk;
      if (bus.i_txn_issue && blk) m_err = 1;
      if (iss && !bus.i_txn_done) begin
        if (m_out == MAXC) m_err = 1; else m_out++;
      end else if (bus.i_txn_done && !iss) begin
        if (m_out == 0) m_err = 1; else m_out--;
      end
      case (pre_st)
        M_OFF: if (bus.i_pwr_on_req) begin m_st = M_RAMP; m_age = 0; end
        M_RAMP:
          if (!bus.i_pwr_on_req) m_st = M_OFF;
          else if (m_age >= RAMP_MIN && bus.i_pwr_good) m_st = M_ON;
          else m_age++;
        M_ON:
          if (!bus.i_pwr_on_req) begin m_st = M_OFF; m_err = 1; end
          else if (bus.i_hw_sleep_req) begin m_st = M_DRAIN; m_qrun = 0; end
        M_DRAIN:
          if (!bus.i_pwr_on_req) begin m_st = M_OFF; m_err = 1; end
          else if (!bus.i_hw_sleep_req) m_st = M_ON;
          else if (m_qrun >= IDLE_HOLD) m_st = M_QUI;
          else m_qrun = quiet_now ? m_qrun + 1 : 0;
        default:
          if (!bus.i_pwr_on_req) m_st = M_OFF;
          else if (!bus.i_hw_sleep_req) m_st = M_ON;
      endcase
      if (m_st == M_OFF && pre_st != M_OFF) m_out = 0;
      m_save     = RET_EN && bus.i_ret && !m_prev_ret;
      m_rest     = RET_EN && !bus.i_ret && m_prev_ret;
      m_prev_ret = bus.i_ret;
    end
  end

  function automatic logic [7:0] exp_sw();
    int n;
    if (m_st == M_OFF) return 8'd0;
    n = SEGS;
    if (m_st == M_RAMP) begin
      n = m_age / STAGE_DLY + 1;
      if (n > SEGS) n = SEGS;
    end
    return 8'((1 << n) - 1);
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("m_sw_en",    8'(bus.o_sw_en),         exp_sw());
      checkOutput("m_pwr_ack",  8'(bus.o_pwr_on_ack),    8'(m_st == M_ON || m_st == M_DRAIN || m_st == M_QUI));
      checkOutput("m_sleep_ack",8'(bus.o_hw_sleep_ack),  8'(m_st == M_QUI));
      checkOutput("m_block",    8'(bus.o_txn_block),     8'(m_st != M_ON));
      checkOutput("m_err",      8'(bus.o_err),           8'(m_err));
      checkOutput("m_save",     8'(bus.o_save_pulse),    8'(m_save));
      checkOutput("m_restore",  8'(bus.o_restore_pulse), 8'(m_rest));
    end
  end

  task automatic applyStimulus(input bit req, sleep, issue, done, busy, good, ret);
    bus.i_pwr_on_req   = req;
    bus.i_hw_sleep_req = sleep;
    bus.i_txn_issue    = issue;
    bus.i_txn_done     = done;
    bus.i_busy         = busy;
    bus.i_pwr_good     = good;
    bus.i_ret          = ret;
  endtask

  task automatic cycle(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    cycle(2);
    rst = 1'b0;
  endtask

  task automatic power_up();
    int w;
    w = 0;
    applyStimulus(1, 0, 0, 0, 0, 1, 0);
    while (bus.o_pwr_on_ack !== 1'b1 && w < 40) begin
      cycle();
      w++;
    end
    checkOutput("pwr_up_ack", 8'(bus.o_pwr_on_ack), 8'd1);
  endtask

  logic [3:0] sw_tab [9] = '{4'h1, 4'h1, 4'h3, 4'h3, 4'h7, 4'h7, 4'hF, 4'hF, 4'hF};
  bit         ack_tab[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};

  bit r_req, r_sleep, r_ret;
  int n_save, n_rest;

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    cycle(2);
    chk_en = 1'b1;
    checkOutput("rst_sw_en", 8'(bus.o_sw_en),      8'h0);
    checkOutput("rst_ack",   8'(bus.o_pwr_on_ack), 8'h0);
    checkOutput("rst_block", 8'(bus.o_txn_block),  8'h1);
    checkOutput("rst_err",   8'(bus.o_err),        8'h0);
    rst = 1'b0;

    // Power-on ramp with rail already good.
    applyStimulus(1, 0, 0, 0, 0, 1, 0);
    for (int c = 0; c < 9; c++) begin
      cycle();
      checkOutput("ramp_sw_en", 8'(bus.o_sw_en),      8'(sw_tab[c]));
      checkOutput("ramp_ack",   8'(bus.o_pwr_on_ack), 8'(ack_tab[c]));
    end
    checkOutput("on_block", 8'(bus.o_txn_block), 8'h0);

    // 3 issues, 1 done, sleep request: two outstanding hold off the ack.
    applyStimulus(1, 0, 1, 0, 0, 1, 0); cycle(3);
    applyStimulus(1, 0, 0, 1, 0, 1, 0); cycle();
    applyStimulus(1, 1, 0, 0, 0, 1, 0); cycle(6);
    checkOutput("drain_no_ack", 8'(bus.o_hw_sleep_ack), 8'h0);
    checkOutput("drain_block",  8'(bus.o_txn_block),    8'h1);
    applyStimulus(1, 1, 0, 1, 0, 1, 0); cycle(2);
    applyStimulus(1, 1, 0, 0, 0, 1, 0); cycle(3);
    checkOutput("quiet3_no_ack", 8'(bus.o_hw_sleep_ack), 8'h0);
    cycle();
    checkOutput("quiet_ack", 8'(bus.o_hw_sleep_ack), 8'h1);

    // Power-off and sleep release together from the quiesced state.
    applyStimulus(0, 0, 0, 0, 0, 1, 0); cycle();
    checkOutput("off_sw_en", 8'(bus.o_sw_en),        8'h0);
    checkOutput("off_ack",   8'(bus.o_pwr_on_ack),   8'h0);
    checkOutput("off_sack",  8'(bus.o_hw_sleep_ack), 8'h0);
    checkOutput("off_err",   8'(bus.o_err),          8'h0);

    // Drain aborted while busy.
    power_up();
    applyStimulus(1, 1, 0, 0, 1, 1, 0); cycle(3);
    checkOutput("abort_pre_sack", 8'(bus.o_hw_sleep_ack), 8'h0);
    applyStimulus(1, 0, 0, 0, 1, 1, 0); cycle();
    checkOutput("abort_block", 8'(bus.o_txn_block),    8'h0);
    checkOutput("abort_sack",  8'(bus.o_hw_sleep_ack), 8'h0);

    // Counter saturation: 16 issues into a 4-bit counter, then drain 15.
    applyStimulus(1, 0, 1, 0, 0, 1, 0); cycle(16);
    checkOutput("sat_err", 8'(bus.o_err), 8'h1);
    applyStimulus(1, 1, 0, 1, 0, 1, 0); cycle(14);
    checkOutput("sat_drain_sack", 8'(bus.o_hw_sleep_ack), 8'h0);
    cycle();
    applyStimulus(1, 1, 0, 0, 0, 1, 0); cycle(4);
    checkOutput("sat_quiet_ack", 8'(bus.o_hw_sleep_ack), 8'h1);
    do_reset();
    checkOutput("rst_clears_err", 8'(bus.o_err), 8'h0);

    // Done at zero is sticky until reset; power drop in PD_ON flags error.
    power_up();
    applyStimulus(1, 0, 0, 1, 0, 1, 0); cycle();
    checkOutput("done0_err", 8'(bus.o_err), 8'h1);
    applyStimulus(1, 0, 0, 0, 0, 1, 0); cycle(5);
    checkOutput("done0_sticky", 8'(bus.o_err), 8'h1);
    do_reset();
    power_up();
    applyStimulus(0, 0, 0, 0, 0, 1, 0); cycle();
    checkOutput("drop_on_err", 8'(bus.o_err),        8'h1);
    checkOutput("drop_on_ack", 8'(bus.o_pwr_on_ack), 8'h0);
    do_reset();

    // Retention toggle 0->1->0.
    n_save = 0; n_rest = 0;
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_save += int'(bus.o_save_pulse);
      n_rest += int'(bus.o_restore_pulse);
    end
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_save += int'(bus.o_save_pulse);
      n_rest += int'(bus.o_restore_pulse);
    end
    checkOutput("save_count",    8'(n_save), 8'(RET_EN));
    checkOutput("restore_count", 8'(n_rest), 8'(RET_EN));

    // Randomized controller and domain traffic.
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      r_req = 0; r_sleep = 0; r_ret = 0;
      for (int i = 0; i < 400; i++) begin
        case (m_st)
          M_OFF:   if ($urandom_range(3) == 0) r_req = 1;
          M_RAMP:  if ($urandom_range(19) == 0) r_req = 0;
          M_ON: begin
            if ($urandom_range(149) == 0) r_req = 0;
            if ($urandom_range(7) == 0) r_sleep = 1;
          end
          M_DRAIN: if ($urandom_range(14) == 0) r_sleep = 0;
          default: begin
            if ($urandom_range(3) == 0) r_req = 0;
            if ($urandom_range(4) == 0) r_sleep = 0;
          end
        endcase
        if ($urandom_range(5) == 0) r_ret = ~r_ret;
        applyStimulus(r_req, r_sleep,
                      (m_st == M_ON) ? ($urandom_range(2) == 0) : ($urandom_range(199) == 0),
                      (m_out > 0) ? ($urandom_range(2) == 0) : ($urandom_range(199) == 0),
                      $urandom_range(4) == 0, $urandom_range(7) != 0, r_ret);
        rst = ($urandom_range(249) == 0);
        cycle();
      end
      rst = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
